// File: rtl/fifo_spi_reader.sv
`timescale 1ns/1ps
// fifo_spi_reader: pops one key event word from an event FIFO per SPI
// chip-select frame and shifts it out to the host MSB first (SPI mode 0).
// Ports:
//   clk, rst           system clock, async active-high reset
//   spi_cs_n, spi_sck  host chip select / serial clock (async to clk)
//   spi_miso           serial event data, spi_miso_oe pad enable
//   fifo_rd            FIFO read request level (FIFO pops on rising edge)
//   fifo_data          FIFO output word (all-zero when FIFO was empty)
//   busy               high outside IDLE/ARMED
//   frame_abort        one-cycle pulse when a frame ends short
module fifo_spi_reader #(
  parameter int unsigned EVENT_WIDTH   = 8,
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   spi_cs_n,
  input  logic                   spi_sck,
  output logic                   spi_miso,
  output logic                   spi_miso_oe,
  output logic                   fifo_rd,
  input  logic [EVENT_WIDTH-1:0] fifo_data,
  output logic                   busy,
  output logic                   frame_abort
);

  localparam int unsigned BIT_W      = $clog2(EVENT_WIDTH) + 1;
  localparam int unsigned CYC_W      = $clog2(SETTLE_CYCLES + 2) + 1;
  localparam int unsigned REQ_CYCLES = 2;

  typedef enum logic [2:0] {
    IDLE, ARMED, REQ, SETTLE, LOAD, SHIFT, DONE
  } state_t;

  state_t                 state_q, state_d;
  logic                   cs_s1_q, cs_s1_d, cs_s2_q, cs_s2_d, cs_prev_q, cs_prev_d;
  logic                   sck_s1_q, sck_s1_d, sck_s2_q, sck_s2_d, sck_prev_q, sck_prev_d;
  logic                   rst_done_q, rst_done_d;
  logic [CYC_W-1:0]       cyc_q, cyc_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [EVENT_WIDTH-1:0] shreg_q, shreg_d;
  logic                   miso_q, miso_d;
  logic                   oe_q, oe_d;
  logic                   fifo_rd_q, fifo_rd_d;
  logic                   busy_q, busy_d;
  logic                   abort_q, abort_d;

  logic cs_rise, cs_fall, sck_rise, sck_fall;

  // Edge detection on synchronized signals only
  assign cs_rise  =  cs_s2_q  & ~cs_prev_q;
  assign cs_fall  = ~cs_s2_q  &  cs_prev_q;
  assign sck_rise =  sck_s2_q & ~sck_prev_q;
  assign sck_fall = ~sck_s2_q &  sck_prev_q;

  // Next-state and registered-output logic
  always_comb begin
    cs_s1_d    = spi_cs_n;
    cs_s2_d    = cs_s1_q;
    cs_prev_d  = cs_s2_q;
    sck_s1_d   = spi_sck;
    sck_s2_d   = sck_s1_q;
    sck_prev_d = sck_s2_q;
    rst_done_d = 1'b1;
    state_d    = state_q;
    cyc_d      = cyc_q;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    miso_d     = miso_q;
    abort_d    = 1'b0;

    case (state_q)
      // Synchronizers come out of reset reading CS high; wait one clock so a
      // CS held low through reset has refilled them before arming.
      IDLE: begin
        if (rst_done_q && cs_s1_q && cs_s2_q) state_d = ARMED;
      end
      ARMED: begin
        if (cs_fall) begin
          state_d = REQ;
          cyc_d   = '0;
        end
      end
      REQ: begin
        if (cs_rise) begin
          state_d = ARMED;
          abort_d = 1'b1;
        end else if (cyc_q == CYC_W'(REQ_CYCLES - 1)) begin
          state_d = (SETTLE_CYCLES == 0) ? LOAD : SETTLE;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      SETTLE: begin
        if (cs_rise) begin
          state_d = ARMED;
          abort_d = 1'b1;
        end else if (cyc_q == CYC_W'(SETTLE_CYCLES - 1)) begin
          state_d = LOAD;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      LOAD: begin
        if (cs_rise) begin
          state_d = ARMED;
          abort_d = 1'b1;
        end else begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = ARMED;
          abort_d = 1'b1;
        end else if (sck_rise) begin
          bit_d = bit_q + BIT_W'(1);
          if (bit_q == BIT_W'(EVENT_WIDTH - 1)) state_d = DONE;
        end else if (sck_fall && (bit_q != '0)) begin
          // A fall with no counted rise (SCK left high from early edges) is skipped
          shreg_d = shreg_q << 1;
          miso_d  = shreg_d[EVENT_WIDTH-1];
        end
      end
      DONE: begin
        if (cs_rise) state_d = ARMED;
      end
      default: state_d = IDLE;
    endcase

    // Latch the popped word on entry to LOAD so MSB is on the pin during LOAD
    if (state_d == LOAD) begin
      shreg_d = fifo_data;
      miso_d  = fifo_data[EVENT_WIDTH-1];
      bit_d   = '0;
    end
    if ((state_d != LOAD) && (state_d != SHIFT)) miso_d = 1'b0;

    fifo_rd_d = (state_d == REQ);
    busy_d    = (state_d != IDLE) && (state_d != ARMED);
    // cs_s1_q is next cycle's synchronized CS, so oe tracks it with no lag
    oe_d      = ~cs_s1_q && (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cs_s1_q    <= 1'b1;
      cs_s2_q    <= 1'b1;
      cs_prev_q  <= 1'b1;
      sck_s1_q   <= 1'b0;
      sck_s2_q   <= 1'b0;
      sck_prev_q <= 1'b0;
      rst_done_q <= 1'b0;
      cyc_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      fifo_rd_q  <= 1'b0;
      busy_q     <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cs_s1_q    <= cs_s1_d;
      cs_s2_q    <= cs_s2_d;
      cs_prev_q  <= cs_prev_d;
      sck_s1_q   <= sck_s1_d;
      sck_s2_q   <= sck_s2_d;
      sck_prev_q <= sck_prev_d;
      rst_done_q <= rst_done_d;
      cyc_q      <= cyc_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
      fifo_rd_q  <= fifo_rd_d;
      busy_q     <= busy_d;
      abort_q    <= abort_d;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign fifo_rd     = fifo_rd_q;
  assign busy        = busy_q;
  assign frame_abort = abort_q;

endmodule

// File: tb/tb_fifo_spi_reader.sv
`timescale 1ns/1ps
// Testbench for fifo_spi_reader: host SPI frames at clk/8 against a queue
// FIFO model; table vectors, hand-written reset/back-to-back sequences and
// randomized frames checked against expected bytes computed from the pushes.
module tb_fifo_spi_reader;

  localparam int unsigned W  = 8;
  localparam int unsigned SC = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         spi_cs_n;
  logic         spi_sck;
  logic         spi_miso;
  logic         spi_miso_oe;
  logic         fifo_rd;
  logic [W-1:0] fifo_data;
  logic         busy;
  logic         frame_abort;

  always #5 clk = ~clk;

  fifo_spi_reader #(.EVENT_WIDTH(W), .SETTLE_CYCLES(SC)) dut (
    .clk         (clk),
    .rst         (rst),
    .spi_cs_n    (spi_cs_n),
    .spi_sck     (spi_sck),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .fifo_rd     (fifo_rd),
    .fifo_data   (fifo_data),
    .busy        (busy),
    .frame_abort (frame_abort)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO model: pops on the rising edge of fifo_rd, zero when empty
  logic [W-1:0] fifo_q[$];
  always @(posedge fifo_rd) begin
    if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
    else                   fifo_data = '0;
  end

  // Protocol monitor: pop count, pulse widths, gap before each pop
  int   pops = 0, aborts = 0, hi_run = 0, lo_run = 0, ab_run = 0;
  logic rd_prev = 1'b0, ab_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      rd_prev = 1'b0; ab_prev = 1'b0; hi_run = 0; lo_run = 0; ab_run = 0;
    end else begin
      if (fifo_rd && !rd_prev) begin
        pops++;
        check("rd_low_gap", 32'(lo_run >= int'(SC)), 1);
        hi_run = 1;
      end else if (fifo_rd) begin
        hi_run++;
      end
      if (!fifo_rd && rd_prev) check("rd_pulse_width", hi_run, 2);
      if (fifo_rd) lo_run = 0; else lo_run++;
      if (frame_abort && !ab_prev) begin aborts++; ab_run = 1; end
      else if (frame_abort) ab_run++;
      if (!frame_abort && ab_prev) check("abort_width", ab_run, 1);
      rd_prev = fifo_rd;
      ab_prev = frame_abort;
    end
  end

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One CS-low frame; returns the first min(nsck,W) sampled bits
  task automatic frame(input int nsck, input bit early, output logic [31:0] got);
    got = '0;
    spi_cs_n = 1'b0;
    if (early) begin
      clks(4); spi_sck = 1'b1; clks(1); spi_sck = 1'b0; clks(11);
    end else begin
      clks(16);
    end
    for (int i = 0; i < nsck; i++) begin
      if (i == 0) begin
        check("oe_in_frame", 32'(spi_miso_oe), 1);
        check("busy_in_frame", 32'(busy), 1);
      end
      if (i < int'(W)) got = {got[30:0], spi_miso};
      else             check("miso_after_done", 32'(spi_miso), 0);
      spi_sck = 1'b1; clks(4);
      spi_sck = 1'b0; clks(4);
    end
    spi_cs_n = 1'b1;
    clks(6);
  endtask

  task automatic run_frame(input logic [W-1:0] data, input bit empty, input int nsck,
                           input bit early, input logic [31:0] exp_val, input int exp_abort);
    logic [31:0] got;
    int p0, a0;
    if (!empty) fifo_q.push_back(data);
    p0 = pops; a0 = aborts;
    frame(nsck, early, got);
    if (nsck > 0) check("data", got, exp_val);
    check("pops_per_frame", pops - p0, 1);
    check("aborts_per_frame", aborts - a0, exp_abort);
    check("rd_after_frame", 32'(fifo_rd), 0);
    check("busy_after_frame", 32'(busy), 0);
    check("oe_after_frame", 32'(spi_miso_oe), 0);
  endtask

  typedef struct {
    logic [W-1:0] data;
    bit           empty;
    int           nsck;
    bit           early;
    logic [31:0]  exp_val;
    int           exp_abort;
  } vec_t;

  vec_t vt[8];

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] got;
    int p0, a0;

    vt[0] = '{8'hA5, 1'b0, 8,  1'b0, 32'hA5, 0};  // normal read
    vt[1] = '{8'h00, 1'b1, 8,  1'b0, 32'h00, 0};  // empty FIFO
    vt[2] = '{8'h81, 1'b0, 3,  1'b0, 32'h04, 1};  // abort after 3 rises, bits 100
    vt[3] = '{8'h3C, 1'b0, 8,  1'b0, 32'h3C, 0};  // frame after abort
    vt[4] = '{8'hC3, 1'b0, 10, 1'b1, 32'hC3, 0};  // early + extra SCK
    vt[5] = '{8'h5A, 1'b0, 0,  1'b0, 32'h00, 1};  // CS pulse with no SCK
    vt[6] = '{8'hFF, 1'b0, 8,  1'b0, 32'hFF, 0};
    vt[7] = '{8'h01, 1'b0, 9,  1'b0, 32'h01, 0};

    rst = 1'b1; spi_cs_n = 1'b1; spi_sck = 1'b0; fifo_data = '0;
    clks(3);
    check("rst_miso", 32'(spi_miso), 0);
    check("rst_oe", 32'(spi_miso_oe), 0);
    check("rst_rd", 32'(fifo_rd), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_abort", 32'(frame_abort), 0);
    rst = 1'b0;
    clks(5);

    for (int i = 0; i < 8; i++)
      run_frame(vt[i].data, vt[i].empty, vt[i].nsck, vt[i].early, vt[i].exp_val, vt[i].exp_abort);

    // Back-to-back frames separated by one idle SCK period
    p0 = pops;
    fifo_q.push_back(8'h12);
    fifo_q.push_back(8'hED);
    frame(8, 1'b0, got); check("b2b_first", got, 32'h12);
    clks(2);
    frame(8, 1'b0, got); check("b2b_second", got, 32'hED);
    check("b2b_pops", pops - p0, 2);

    // Reset mid-SHIFT with CS held low
    fifo_q.push_back(8'h96);
    p0 = pops; a0 = aborts;
    spi_cs_n = 1'b0;
    clks(16);
    for (int i = 0; i < 3; i++) begin
      spi_sck = 1'b1; clks(4); spi_sck = 1'b0; clks(4);
    end
    check("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_miso", 32'(spi_miso), 0);
    check("mid_rst_oe", 32'(spi_miso_oe), 0);
    check("mid_rst_rd", 32'(fifo_rd), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_abort", 32'(frame_abort), 0);
    clks(2);
    rst = 1'b0;
    clks(30);
    check("post_rst_pops", pops - p0, 1);
    check("post_rst_aborts", aborts - a0, 0);
    check("post_rst_oe", 32'(spi_miso_oe), 0);
    check("post_rst_busy", 32'(busy), 0);
    spi_cs_n = 1'b1;
    clks(8);
    run_frame(8'h69, 1'b0, 8, 1'b0, 32'h69, 0);

    // Randomized frames against the queue-level expectation
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] d;
      logic [31:0]  v;
      bit           e;
      int           ns, nb;
      d  = W'($urandom_range(0, 255));
      e  = ($urandom_range(0, 7) == 0);
      ns = $urandom_range(0, 11);
      nb = (ns < int'(W)) ? ns : int'(W);
      v  = e ? 32'h0 : 32'(d);
      v  = (nb > 0) ? (v >> (int'(W) - nb)) : 32'h0;
      run_frame(d, e, ns, 1'($urandom_range(0, 1)), v, (ns < int'(W)) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
